timer_counter: RTL
==================

// Module: timer_counter
// PURPOSE
//  Memory-mapped down-counting timer: responder side of the load/store address window
//  at 0x7f00-0x7f0b (Timer0) or 0x7f10-0x7f1b (Timer1). Instantiated twice behind the bridge.
//  Word access only: the E-stage exception check already raises AdEL/AdES for sub-word
//  accesses to this window.
//  Counts PRESET down to 0 and raises IRQ toward CP0 HWInt.
// PARAMETERS
//  BASE_ADDR  32'h0000_7f00  window base; Timer1 instance uses 32'h0000_7f10
// PORTS
//  clk    in   1   system clock; all state changes on posedge
//  reset  in   1   synchronous, active-high
//  Addr   in   30  word address [31:2] from M stage
//  WE     in   1   write strobe (bridge-qualified, word store)
//  Din    in   32  write data
//  Dout   out  32  read data, combinational
//  IRQ    out  1   interrupt request, level
// BEHAVIOUR
//  Register map (hit = Addr[31:4]==BASE_ADDR[31:4]; offset = Addr[3:2]):
//   00 CTRL   R/W: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x = one-shot),
//             [3] IM irq mask; bits [31:4] read 0, writes ignored
//   01 PRESET R/W, 32 bit
//   10 COUNT  read-only; writes ignored
//   11        reads 32'h0; writes ignored
//  Dout: selected register when hit, 32'h0 otherwise. No read side effects.
//  Write: WE & hit, takes effect at the next posedge.
//   Write to CTRL also clears irq_flag.
//  Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
//   Hence IRQ=0 and Dout=0 for every offset.
//  FSM (one transition per cycle):
//   IDLE: EN=1 -> LOAD
//   LOAD: COUNT<=PRESET (value before any same-cycle PRESET write) -> CNT
//   CNT : EN=0 -> IDLE, COUNT held.
//         Else COUNT==0 -> INT, irq_flag<=1.
//         Else COUNT<=COUNT-1.
//   INT : MODE!=01 -> EN<=0, ->IDLE; irq_flag stays 1 until CTRL write
//         MODE==01 -> ->IDLE, irq_flag<=0 (one-cycle pulse), re-LOADs next cycle
//  Interval: EN write at cycle t -> IDLE(t+1) LOAD(t+2) CNT from t+3.
//   irq_flag=1 visible at cycle t+4+PRESET.
//  Auto-reload period = PRESET+4 cycles (INT, IDLE, LOAD, CNT x(PRESET+1)).
//  PRESET=0: COUNT reaches 0 with no decrement; INT follows the first CNT cycle.
//   There is no wrap-around: COUNT never decrements below 0.
//  IRQ = irq_flag & CTRL[3]. Changing IM hides or exposes a pending flag without clearing it.
//  Simultaneous events:
//   - CTRL write in INT: the software value wins over the FSM clear of EN. The flag clears.
//   - CTRL write with EN=0 in CNT: the FSM sees the old EN that cycle and IDLE follows.
//  Reset asserted mid-count: all state returns to reset values at that posedge.
// TESTING
//  1 reset 2 cycles -> Dout=0 at offsets 0/4/8/c, IRQ=0.
//  2 PRESET=5, CTRL=9 (EN, one-shot, IM) -> COUNT reads 5,4,..,0.
//    IRQ=1 at t+9 and held; CTRL reads 8. Writing CTRL=0 -> IRQ=0 next cycle.
//  3 PRESET=2, CTRL=0xb (auto-reload) -> IRQ one-cycle pulses every 6 cycles.
//    EN stays 1 and COUNT reloads to 2.
//  4 PRESET=0, one-shot, IM=0 -> irq_flag set at t+4, IRQ=0.
//    A later CTRL write of 8 -> IRQ=0 (flag cleared by the write).
//  5 write COUNT=0x1234 and offset c -> no change. A write to BASE+0x10 on a Timer0
//    instance -> ignored; Dout=0 for a non-hit address.
//  6 reset mid-CNT with COUNT=3 -> next cycle all registers 0, state IDLE, IRQ=0.

Source files
------------

// File: rtl/timer_counter_if.sv
// Bus bundle between the load/store bridge and one timer_counter instance.
interface timer_counter_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a level IRQ.
// Two instances sit behind the bridge, distinguished by BASE_ADDR.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irqFlag_q;

    logic        hit;
    logic [1:0]  offset;
    logic        wrCtrl;
    logic        wrPreset;
    logic [31:0] readData;

    assign hit      = (bus.Addr[29:2] == BASE_ADDR[31:4]);
    assign offset   = bus.Addr[1:0];
    assign wrCtrl   = bus.WE && hit && (offset == OFF_CTRL);
    assign wrPreset = bus.WE && hit && (offset == OFF_PRESET);

    // Register writes come after the FSM so a software CTRL write overrides
    // the FSM's EN clear and irq_flag update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            irqFlag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_q[0]) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= IDLE;
                    end else if (count_q == 32'd0) begin
                        state_q   <= INT;
                        irqFlag_q <= 1'b1;
                    end else begin
                        count_q <= count_q - 32'd1;
                    end
                end
                INT: begin
                    state_q <= IDLE;
                    if (ctrl_q[2:1] == MODE_AUTO) begin
                        irqFlag_q <= 1'b0;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (wrPreset) begin
                preset_q <= bus.Din;
            end
            if (wrCtrl) begin
                ctrl_q    <= bus.Din[3:0];
                irqFlag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        readData = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   readData = {28'd0, ctrl_q};
                OFF_PRESET: readData = preset_q;
                OFF_COUNT:  readData = count_q;
                default:    readData = '0;
            endcase
        end
    end

    assign bus.Dout = readData;
    assign bus.IRQ  = irqFlag_q & ctrl_q[3];

endmodule
